// File: rtl/vga_scaler_out.sv
// vga_scaler_out: VGA timing generator that shows a 2x-upscaled source frame from an RGB stream.
// Ports: clk/reset (sync, active-high); start arms the next frame; pix_valid/pix_r/g/b/pix_ready
// form the upstream pixel handshake; hsync/vsync/blank/vga_r/g/b drive the display;
// frame_done pulses after a shown frame ends; underrun is sticky when a pixel was missing.
// Define VGA_TEST_PATTERN_EN to show colour bars instead of black while idle or armed.
module vga_scaler_out #(
    parameter int   IMAGE_WIDTH  = 320,
    parameter int   IMAGE_HEIGHT = 240,
    parameter int   H_ACTIVE     = 640,
    parameter int   H_FP         = 16,
    parameter int   H_SYNC       = 96,
    parameter int   H_BP         = 48,
    parameter int   V_ACTIVE     = 480,
    parameter int   V_FP         = 10,
    parameter int   V_SYNC       = 2,
    parameter int   V_BP         = 33,
    parameter logic SYNC_POL     = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pix_valid,
    input  logic [7:0] pix_r,
    input  logic [7:0] pix_g,
    input  logic [7:0] pix_b,
    output logic       pix_ready,
    output logic       hsync,
    output logic       vsync,
    output logic       blank,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       frame_done,
    output logic       underrun
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int AW = $clog2(IMAGE_WIDTH);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_END  = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_SRC  = HW'(2 * IMAGE_WIDTH);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_END  = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_SRC  = VW'(2 * IMAGE_HEIGHT);

    typedef enum logic [1:0] {IDLE, ARMED, SHOW} state_t;

    state_t        state, state_nx;
    logic [HW-1:0] h_cnt, h_nx;
    logic [VW-1:0] v_cnt, v_nx;
    logic [23:0]   lbuf [IMAGE_WIDTH];
    logic [23:0]   hold_px, rd_px, cur_px, show_px, idle_px, rgb_nx;
    logic [AW-1:0] rd_addr;
    logic          act, ready_nx, und_nx, fd_nx;
`ifdef VGA_TEST_PATTERN_EN
    logic [2:0]    bar;
`endif

    always_comb begin
        h_nx = (h_cnt == H_LAST) ? '0 : h_cnt + 1'b1;
        v_nx = (h_cnt != H_LAST) ? v_cnt : (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? ARMED : IDLE;
            ARMED:   state_nx = (h_nx == '0 && v_nx == '0) ? SHOW : ARMED;
            SHOW:    state_nx = (h_cnt == H_END && v_cnt == V_END) ? IDLE : SHOW;
            default: state_nx = IDLE;
        endcase
        act = h_cnt < H_ACT && v_cnt < V_ACT;
        cur_px = pix_valid ? {pix_r, pix_g, pix_b} : '0;
        // even lines: fresh pixel on even columns, held copy on odd; odd lines replay the buffer
        show_px = v_cnt[0] ? rd_px : h_cnt[0] ? hold_px : cur_px;
`ifdef VGA_TEST_PATTERN_EN
        bar = 3'(h_cnt / HW'(H_ACTIVE / 8));
        idle_px = {{8{!bar[1]}}, {8{!bar[2]}}, {8{!bar[0]}}};
`else
        idle_px = '0;
`endif
        rgb_nx = !act ? '0 : (state == SHOW) ? show_px : idle_px;
        // pix_ready is a register, so it is decided from the next counter position and state
        ready_nx = state_nx == SHOW && h_nx < H_SRC && v_nx < V_SRC && !h_nx[0] && !v_nx[0];
        fd_nx = state == SHOW && state_nx == IDLE;
        und_nx = (pix_ready && !pix_valid) || (underrun && !(state == ARMED && state_nx == SHOW));
        // prefetch the entry for the next column so the buffer read lines up with the output register
        rd_addr = (h_nx < H_SRC) ? h_nx[AW:1] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt      <= '0;
            v_cnt      <= '0;
            pix_ready  <= 1'b0;
            hsync      <= !SYNC_POL;
            vsync      <= !SYNC_POL;
            blank      <= 1'b1;
            {vga_r, vga_g, vga_b} <= '0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            h_cnt      <= h_nx;
            v_cnt      <= v_nx;
            pix_ready  <= ready_nx;
            hsync      <= (h_cnt >= H_SS && h_cnt < H_SE) ? SYNC_POL : !SYNC_POL;
            vsync      <= (v_cnt >= V_SS && v_cnt < V_SE) ? SYNC_POL : !SYNC_POL;
            blank      <= !act;
            {vga_r, vga_g, vga_b} <= rgb_nx;
            frame_done <= fd_nx;
            underrun   <= und_nx;
        end
    end

    // line buffer survives reset; only the pixel datapath lives here
    always_ff @(posedge clk) begin
        if (pix_ready) begin
            hold_px <= cur_px;
            lbuf[h_cnt[AW:1]] <= cur_px;
        end
        rd_px <= lbuf[rd_addr];
    end
endmodule
